prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
Parametrised, runtime-programmable multi-channel clock divider. It is the successor to the fixed 50 MHz to 1 kHz divider. Each of N_CH channels produces a 50%-duty divided clock and a one-cycle tick strobe from the single system clock. Half-period divisors are loaded at runtime, and each takes effect glitch-free at that channel's next phase boundary. All logic uses the rising edge of CLK only.

Parameters:
N_CH, 2, number of independent output channels (1..8)
DIV_W, 16, width of half-period divisor and channel counter
DEFAULT_HALF, 25000, reset half-period in CLK cycles (50 MHz -> 1 kHz)
SEL_W, 3, width of DIV_SEL (must satisfy 2**SEL_W >= N_CH)

Ports:
CLK  input  1  system clock (50 MHz nominal)
RST  input  1  asynchronous, active-high reset
EN  input  N_CH  per-channel run enable
DIV_LOAD  input  1  one-cycle strobe: write DIV_IN to channel DIV_SEL
DIV_SEL  input  SEL_W  target channel index for DIV_LOAD
DIV_IN  input  DIV_W  new half-period H (output period = 2*H cycles)
CLK_OUT  output  N_CH  divided clocks, registered
TICK  output  N_CH  one-CLK pulse coincident with each CLK_OUT rising edge
PENDING  output  N_CH  shadow divisor waiting to be applied

Behaviour:
- Reset (async assert, sync release): counters=0, CLK_OUT=0, TICK=0, PENDING=0, active=shadow=DEFAULT_HALF for every channel.
- Per channel, EN=1 and active H>=1: counter increments each CLK. At terminal count (counter==H-1), counter wraps to 0 and CLK_OUT toggles.
- Result: CLK_OUT is high for H cycles and low for H cycles; period is 2H; duty is exactly 50%.
- First CLK_OUT rise occurs on the H-th CLK edge after EN is sampled high.
- TICK is asserted on the same edge CLK_OUT goes 0->1 and lasts exactly one cycle. No TICK on the falling toggle.
- H=1: CLK_OUT toggles every cycle (CLK/2); TICK pulses every second cycle.
- H=0: channel stopped. Counter held at 0, CLK_OUT=0, TICK=0, regardless of EN.
- EN=0: counter cleared to 0, CLK_OUT and TICK forced 0 on next edge. Re-enable restarts a full low phase (no runt high pulse).
- DIV_LOAD with DIV_SEL<N_CH: DIV_IN is written to that channel's shadow and PENDING is set.
  - Shadow is copied to active at the channel's next terminal count; PENDING clears on the same edge.
  - If the channel is disabled or active H=0, the copy happens on the next edge.
- DIV_LOAD coincident with terminal count: DIV_IN becomes active directly for the phase starting at that edge; PENDING stays 0.
- Repeated DIV_LOAD while pending: last write wins; applied once.
- DIV_LOAD with DIV_SEL>=N_CH: ignored, no state change.
- Counter compare uses the active value only. Counter never exceeds H-1; no wrap at 2**DIV_W.
- Channels are fully independent. A load to one channel never disturbs the phase of another.
- RST asserted mid-operation: all outputs drop to reset values immediately (asynchronous). Programmed divisors revert to DEFAULT_HALF.

Decomposition:
- Shared package clkdiv_pkg holds:
  - DIV_W and DEFAULT_HALF defaults
  - CLK_HZ constant (50_000_000)
  - a constant function half_for_hz(f) returning CLK_HZ/(2*f) for testbench and integrator use
- One sub-module, clkdiv_channel: counter, active/shadow registers, toggle, tick and pending logic for a single channel.
- Top prog_clock_divider instantiates N_CH copies via generate and decodes DIV_LOAD/DIV_SEL into per-channel load strobes.

Test Plan:
1. Reset, EN[0]=1, default H=25000 -> CLK_OUT[0] first rises at edge 25000, period 50000 cycles, high 25000, one TICK per period.
2. Load ch0 H=3 while disabled, then EN[0]=1 -> CLK_OUT[0] pattern 000111 repeating, TICK[0] on each 0->1, PENDING[0] high for one cycle after load.
3. Ch0 running H=4; load H=2 at counter=1 -> current phase completes at 4 cycles, following phases are 2 cycles, no runt pulse, PENDING[0] clears at that wrap; ch1 (H=5) phase unaffected.
4. Load H=1 to ch1 -> CLK_OUT[1] toggles every cycle, TICK[1] every second cycle. Load H=0 -> CLK_OUT[1] held 0, no TICK.
5. DIV_LOAD with DIV_SEL=N_CH (e.g. 2 when N_CH=2) and DIV_IN=7 -> no change to any active or shadow value, PENDING stays 0.
6. Assert RST mid-high-phase with ch0 H=3 -> CLK_OUT, TICK, PENDING go 0 without waiting for CLK. After release with EN[0]=1, period is back to 50000 cycles.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package clkdiv_pkg;

  // Default counter / divisor width.
  localparam int DEF_DIV_W = 16;

  // Default half-period: 50 MHz in, 1 kHz out.
  localparam int DEF_HALF = 25000;

  // Nominal system clock frequency in Hz.
  localparam int unsigned CLK_HZ = 50_000_000;

  // Half-period in CLK cycles for an output frequency f (Hz); 0 for f == 0.
  function automatic int unsigned half_for_hz(input int unsigned f);
    if (f == 0) return 0;
    return CLK_HZ / (2 * f);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: phase counter, active/shadow divisor, toggle, tick, pending.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W        = DEF_DIV_W,
  parameter int DEFAULT_HALF = DEF_HALF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             pending_q, pending_d;
  logic             running;
  logic             terminal;

  // Next-state: counting/toggling, then divisor handover at phase boundaries.
  always_comb begin
    running     = en && (active_q != '0);
    terminal    = running && (cnt_q == (active_q - DIV_W'(1)));
    cnt_d       = cnt_q;
    active_d    = active_q;
    shadow_d    = shadow_q;
    clk_out_d   = clk_out_q;
    tick_d      = 1'b0;
    pending_d   = pending_q;

    if (running) begin
      if (terminal) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        // Only the low-to-high toggle produces a tick.
        tick_d    = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      // Stopped or disabled: park in a full low phase so restart has no runt.
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end

    if (load) begin
      if (terminal) begin
        // New divisor governs the phase that starts on this very edge.
        active_d  = div_in;
        shadow_d  = div_in;
        pending_d = 1'b0;
      end else begin
        // Latest write wins; applied once at the next boundary.
        shadow_d  = div_in;
        pending_d = 1'b1;
      end
    end else if (pending_q && (terminal || !running)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // State registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      active_q  <= DIV_W'(DEFAULT_HALF);
      shadow_q  <= DIV_W'(DEFAULT_HALF);
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider top level.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int DIV_W        = DEF_DIV_W,
  parameter int DEFAULT_HALF = DEF_HALF,
  parameter int SEL_W        = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_CH-1:0]  EN,
  input  logic             DIV_LOAD,
  input  logic [SEL_W-1:0] DIV_SEL,
  input  logic [DIV_W-1:0] DIV_IN,
  output logic [N_CH-1:0]  CLK_OUT,
  output logic [N_CH-1:0]  TICK,
  output logic [N_CH-1:0]  PENDING
);

  // Load interface: DIV_LOAD is a single-cycle strobe with no back-pressure;
  // DIV_SEL/DIV_IN are sampled on the same edge. Out-of-range DIV_SEL decodes
  // to no channel, so such writes vanish without side effects.
  logic [N_CH-1:0] load_ch;

  // Decode the load strobe into one-hot per-channel strobes.
  always_comb begin
    load_ch = '0;
    for (int i = 0; i < N_CH; i++) begin
      load_ch[i] = DIV_LOAD && (DIV_SEL == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clkdiv_channel #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk     (CLK),
      .rst     (RST),
      .en      (EN[g]),
      .load    (load_ch[g]),
      .div_in  (DIV_IN),
      .clk_out (CLK_OUT[g]),
      .tick    (TICK[g]),
      .pending (PENDING[g])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scenario bench for prog_clock_divider (2 channels, 16-bit divisors).
module tb_prog_clock_divider;

  localparam int N_CH  = 2;
  localparam int DIV_W = 16;
  localparam int SEL_W = 3;
  localparam int H_DEF = 25000;

  logic             clk;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             div_load;
  logic [SEL_W-1:0] div_sel;
  logic [DIV_W-1:0] div_in;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;

  // Sample layout: {clk_out[1], clk_out[0], tick[1], tick[0], pending[1:0]}
  logic [5:0] exp_q[$];
  logic [5:0] exp_v;
  int checks;
  int failures;

  prog_clock_divider #(
    .N_CH         (N_CH),
    .DIV_W        (DIV_W),
    .DEFAULT_HALF (H_DEF),
    .SEL_W        (SEL_W)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .EN       (en),
    .DIV_LOAD (div_load),
    .DIV_SEL  (div_sel),
    .DIV_IN   (div_in),
    .CLK_OUT  (clk_out),
    .TICK     (tick),
    .PENDING  (pending)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: every scenario is a fixed-length loop, this only guards a stall.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Ideal channel waveform k edges after enable with half-period h: {clk_out, tick}.
  function automatic logic [1:0] run_exp(input int k, input int h);
    logic co;
    logic t;
    co = ((k / h) % 2) == 1;
    t  = (k % (2 * h)) == h;
    return {co, t};
  endfunction

  function automatic logic [5:0] pack(input logic [1:0] c0, input logic [1:0] c1,
                                      input logic [1:0] p);
    return {c1[1], c0[1], c1[0], c0[0], p};
  endfunction

  task automatic test_reset();
    rst = 1'b0; en = '0; div_load = 1'b0; div_sel = '0; div_in = '0;
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(6'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({clk_out, tick, pending} !== exp_v) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", {clk_out, tick, pending}, exp_v);
    end
    repeat (2) edge_step();
    exp_q.push_back(6'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({clk_out, tick, pending} !== exp_v) begin
      failures++;
      $display("FAIL reset_held got=%b exp=%b", {clk_out, tick, pending}, exp_v);
    end
    rst = 1'b0;
  endtask

  // Default half-period: first rise and tick exactly on edge 25000.
  task automatic test_default_div();
    for (int k = 1; k <= H_DEF; k++) begin
      en = 2'b01;
      exp_q.push_back(pack({k == H_DEF, k == H_DEF}, 2'b00, 2'b00));
      edge_step();
      exp_v = exp_q.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== exp_v) begin
        failures++;
        $display("FAIL default_div k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, exp_v);
      end
    end
    en = 2'b00;
    exp_q.push_back(6'b0);
    edge_step();
    exp_v = exp_q.pop_front();
    checks++;
    if ({clk_out, tick, pending} !== exp_v) begin
      failures++;
      $display("FAIL default_disable got=%b exp=%b", {clk_out, tick, pending}, exp_v);
    end
  endtask

  // Load while disabled: pending one cycle, then H=3 waveform 000111.
  task automatic test_load_disabled();
    en = 2'b00; div_load = 1'b1; div_sel = 3'd0; div_in = 16'd3;
    exp_q.push_back(6'b000001);
    edge_step();
    div_load = 1'b0;
    exp_q.push_back(6'b000000);
    exp_v = exp_q.pop_front();
    checks++;
    if ({clk_out, tick, pending} !== exp_v) begin
      failures++;
      $display("FAIL load_dis_pending got=%b exp=%b", {clk_out, tick, pending}, exp_v);
    end
    edge_step();
    exp_v = exp_q.pop_front();
    checks++;
    if ({clk_out, tick, pending} !== exp_v) begin
      failures++;
      $display("FAIL load_dis_applied got=%b exp=%b", {clk_out, tick, pending}, exp_v);
    end
    for (int k = 1; k <= 14; k++) begin
      en = 2'b01;
      exp_q.push_back(pack(run_exp(k, 3), 2'b00, 2'b00));
      edge_step();
      exp_v = exp_q.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== exp_v) begin
        failures++;
        $display("FAIL load_dis_wave k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, exp_v);
      end
    end
    en = 2'b00;
    edge_step();
  endtask

  // ch0 H=4 -> 2 mid-phase, then 2 -> 3 on a terminal edge; ch1 H=5 untouched.
  task automatic test_phase_change();
    logic [1:0] c0;
    logic [1:0] p;
    int j;
    en = 2'b00; div_load = 1'b1; div_sel = 3'd0; div_in = 16'd4;
    exp_q.push_back(6'b000001);
    edge_step();
    div_sel = 3'd1; div_in = 16'd5;
    exp_q.push_back(6'b000010);
    exp_v = exp_q.pop_front();
    checks++;
    if ({clk_out, tick, pending} !== exp_v) begin
      failures++;
      $display("FAIL phase_setup0 got=%b exp=%b", {clk_out, tick, pending}, exp_v);
    end
    edge_step();
    div_load = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if ({clk_out, tick, pending} !== exp_v) begin
      failures++;
      $display("FAIL phase_setup1 got=%b exp=%b", {clk_out, tick, pending}, exp_v);
    end
    edge_step();
    for (int k = 1; k <= 30; k++) begin
      en       = 2'b11;
      div_load = (k == 2) || (k == 16);
      div_sel  = 3'd0;
      div_in   = (k == 2) ? 16'd2 : 16'd3;
      if (k < 4) begin
        c0 = 2'b00;
      end else if (k <= 16) begin
        j  = k - 4;
        c0 = {((j / 2) % 2) == 0, (j % 4) == 0};
      end else begin
        j  = k - 16;
        c0 = {((j / 3) % 2) == 0, (j % 6) == 0};
      end
      p = {1'b0, (k == 2) || (k == 3)};
      exp_q.push_back(pack(c0, run_exp(k, 5), p));
      edge_step();
      exp_v = exp_q.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== exp_v) begin
        failures++;
        $display("FAIL phase_change k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, exp_v);
      end
    end
    div_load = 1'b0;
    en = 2'b00;
    edge_step();
  endtask

  // ch1 H=1 gives CLK/2 with tick every other cycle; H=0 stops it while enabled.
  task automatic test_h1_h0();
    en = 2'b00; div_load = 1'b1; div_sel = 3'd1; div_in = 16'd1;
    edge_step();
    div_load = 1'b0;
    edge_step();
    for (int k = 1; k <= 16; k++) begin
      en       = 2'b10;
      div_load = (k == 9);
      div_sel  = 3'd1;
      div_in   = 16'd0;
      if (k <= 9) exp_q.push_back(pack(2'b00, {k % 2 == 1, k % 2 == 1}, 2'b00));
      else        exp_q.push_back(6'b0);
      edge_step();
      exp_v = exp_q.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== exp_v) begin
        failures++;
        $display("FAIL h1_h0 k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, exp_v);
      end
    end
    div_load = 1'b0;
    en = 2'b00;
    edge_step();
  endtask

  // Out-of-range selects change nothing: ch0 keeps H=3, ch1 keeps H=0.
  task automatic test_bad_sel();
    en = 2'b00; div_load = 1'b1; div_in = 16'd7;
    for (int s = 2; s <= 7; s += 5) begin
      div_sel = SEL_W'(s);
      exp_q.push_back(6'b0);
      edge_step();
      exp_v = exp_q.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== exp_v) begin
        failures++;
        $display("FAIL bad_sel sel=%0d got=%b exp=%b", s, {clk_out, tick, pending}, exp_v);
      end
    end
    div_load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      en = 2'b11;
      exp_q.push_back(pack(run_exp(k, 3), 2'b00, 2'b00));
      edge_step();
      exp_v = exp_q.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== exp_v) begin
        failures++;
        $display("FAIL bad_sel_wave k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, exp_v);
      end
    end
    en = 2'b00;
    edge_step();
  endtask

  // Reset mid-high-phase with a pending load; afterwards the default divisor is back.
  task automatic test_async_reset();
    for (int k = 1; k <= 4; k++) begin
      en       = 2'b01;
      div_load = (k == 4);
      div_sel  = 3'd0;
      div_in   = 16'd5;
      exp_q.push_back(pack(run_exp(k, 3), 2'b00, {1'b0, k == 4}));
      edge_step();
      exp_v = exp_q.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== exp_v) begin
        failures++;
        $display("FAIL pre_reset k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, exp_v);
      end
    end
    div_load = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(6'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({clk_out, tick, pending} !== exp_v) begin
      failures++;
      $display("FAIL async_reset_drop got=%b exp=%b", {clk_out, tick, pending}, exp_v);
    end
    repeat (2) edge_step();
    rst = 1'b0;
    for (int k = 1; k <= H_DEF; k++) begin
      en = 2'b01;
      exp_q.push_back(pack({k == H_DEF, k == H_DEF}, 2'b00, 2'b00));
      edge_step();
      exp_v = exp_q.pop_front();
      checks++;
      if ({clk_out, tick, pending} !== exp_v) begin
        failures++;
        $display("FAIL post_reset k=%0d got=%b exp=%b", k, {clk_out, tick, pending}, exp_v);
      end
    end
    en = 2'b00;
  endtask

  // Test sequence and final report
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_default_div();
    test_load_disabled();
    test_phase_change();
    test_h1_h0();
    test_bad_sel();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
